connect_merge: RTL and testbench

N-to-1 merge for the valid/ready dataflow channel: collects tokens from CONNECT_NUM upstream channels and forwards them one at a time on a single downstream channel. It is the converging counterpart of connect_fork and sits wherever several producers feed one consumer, for example several PE outputs feeding one matching-unit input. Arbitration is round-robin. The output stage is registered, and each forwarded word carries the index of its source channel.

---
 rtl/connect_merge_if.sv | 31 +++
 rtl/connect_merge.sv | 94 +++++++++
 tb/tb_connect_merge.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/connect_merge_if.sv
// connect_merge_if: N upstream valid/ready channels converging onto one tagged downstream channel.
// Revision 1.0
`default_nettype none

interface connect_merge_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int CONNECT_NUM = 3,
  parameter int INDEX_WIDTH = 2
);
  logic [CONNECT_NUM-1:0]            RECEIVE_VALID;
  logic [DATA_WIDTH*CONNECT_NUM-1:0] RECEIVE_DATA;
  logic [CONNECT_NUM-1:0]            RECEIVE_READY;
  logic                              SEND_VALID;
  logic [DATA_WIDTH-1:0]             SEND_DATA;
  logic [INDEX_WIDTH-1:0]            SEND_INDEX;
  logic                              SEND_READY;

  // Environment side: produces upstream tokens, consumes downstream tokens.
  modport master (
    output RECEIVE_VALID, RECEIVE_DATA, SEND_READY,
    input  RECEIVE_READY, SEND_VALID, SEND_DATA, SEND_INDEX
  );

  // Merge side.
  modport slave (
    input  RECEIVE_VALID, RECEIVE_DATA, SEND_READY,
    output RECEIVE_READY, SEND_VALID, SEND_DATA, SEND_INDEX
  );
endinterface

`default_nettype wire

// File: rtl/connect_merge.sv
// connect_merge: round-robin N-to-1 valid/ready merge with a registered, source-tagged output stage.
// Revision 1.0
`default_nettype none

module connect_merge #(
  parameter int DATA_WIDTH  = 32,
  parameter int CONNECT_NUM = 3,
  parameter int INDEX_WIDTH = 2
) (
  input  logic           CLK,
  input  logic           RST,
  connect_merge_if.slave bus
);

  logic                   send_valid;
  logic [DATA_WIDTH-1:0]  send_data;
  logic [INDEX_WIDTH-1:0] send_index;
  logic [INDEX_WIDTH-1:0] last;

  logic                   load;
  logic                   any_valid;
  logic                   found_hi;
  logic                   found_lo;
  logic [INDEX_WIDTH-1:0] grant_hi;
  logic [INDEX_WIDTH-1:0] grant_lo;
  logic [INDEX_WIDTH-1:0] grant;
  logic [DATA_WIDTH-1:0]  grant_data;
  logic [CONNECT_NUM-1:0] ready;
  logic [DATA_WIDTH-1:0]  chan_data [CONNECT_NUM];

  generate
    for (genvar i = 0; i < CONNECT_NUM; i++) begin : g_unpack
      assign chan_data[i] = bus.RECEIVE_DATA[DATA_WIDTH*(i+1)-1 -: DATA_WIDTH];
    end
  endgenerate

  assign load = !send_valid || bus.SEND_READY;

  // Lowest valid index above last wins; otherwise wrap to the lowest valid index at or below last.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    grant_hi = '0;
    grant_lo = '0;
    for (int i = CONNECT_NUM - 1; i >= 0; i--) begin
      if (bus.RECEIVE_VALID[i]) begin
        if (i > int'(last)) begin
          found_hi = 1'b1;
          grant_hi = i[INDEX_WIDTH-1:0];
        end else begin
          found_lo = 1'b1;
          grant_lo = i[INDEX_WIDTH-1:0];
        end
      end
    end
    any_valid = found_hi || found_lo;
    grant     = found_hi ? grant_hi : grant_lo;
  end

  always_comb begin
    grant_data = '0;
    ready      = '0;
    for (int i = 0; i < CONNECT_NUM; i++) begin
      if (grant == i[INDEX_WIDTH-1:0]) begin
        grant_data = chan_data[i];
        ready[i]   = any_valid && load;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      send_valid <= 1'b0;
      send_data  <= '0;
      send_index <= '0;
      last       <= INDEX_WIDTH'(CONNECT_NUM - 1);
    end else if (load) begin
      send_valid <= any_valid;
      if (any_valid) begin
        send_data  <= grant_data;
        send_index <= grant;
        last       <= grant;
      end
    end
  end

  assign bus.RECEIVE_READY = ready;
  assign bus.SEND_VALID    = send_valid;
  assign bus.SEND_DATA     = send_data;
  assign bus.SEND_INDEX    = send_index;

endmodule

`default_nettype wire

// File: tb/tb_connect_merge.sv
// tb_connect_merge: directed-vector bench for connect_merge with CONNECT_NUM=3.
// Revision 1.0
`default_nettype none

module tb_connect_merge;
  localparam int DW = 32;
  localparam int N  = 3;
  localparam int IW = 2;

  logic CLK;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  connect_merge_if #(.DATA_WIDTH(DW), .CONNECT_NUM(N), .INDEX_WIDTH(IW)) bus ();

  connect_merge #(.DATA_WIDTH(DW), .CONNECT_NUM(N), .INDEX_WIDTH(IW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [DW-1:0] d);
    bus.RECEIVE_DATA[DW*ch +: DW] = d;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [DW-1:0] d, input logic [IW-1:0] idx);
    check({tag, "_valid"}, 64'(bus.SEND_VALID), 64'(v));
    check({tag, "_data"},  64'(bus.SEND_DATA),  64'(d));
    check({tag, "_index"}, 64'(bus.SEND_INDEX), 64'(idx));
  endtask

  initial begin
    logic [IW-1:0] rr_exp [6];
    logic [IW-1:0] skip_exp [4];
    rr_exp   = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    skip_exp = '{2'd0, 2'd2, 2'd0, 2'd2};

    RST = 1'b1;
    bus.RECEIVE_VALID = '0;
    bus.RECEIVE_DATA  = '0;
    bus.SEND_READY    = 1'b1;

    // Reset then idle
    tick();
    tick();
    check_out("reset", 1'b0, '0, '0);
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("idle_ready", 64'(bus.RECEIVE_READY), 64'(3'b000));
      tick();
      check_out("idle", 1'b0, '0, '0);
    end

    // Single channel streaming back-to-back
    for (int k = 0; k < 4; k++) begin
      bus.RECEIVE_VALID = 3'b010;
      set_ch(1, 32'hA0 + 32'(k));
      #1;
      check("single_ready", 64'(bus.RECEIVE_READY), 64'(3'b010));
      tick();
      check_out("single", 1'b1, 32'hA0 + 32'(k), 2'd1);
    end
    bus.RECEIVE_VALID = '0;
    tick();
    check("single_drain", 64'(bus.SEND_VALID), 64'(0));

    // Round-robin from reset with all channels valid
    RST = 1'b1;
    tick();
    RST = 1'b0;
    set_ch(0, 32'h10);
    set_ch(1, 32'h20);
    set_ch(2, 32'h30);
    bus.RECEIVE_VALID = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_ready", 64'(bus.RECEIVE_READY), 64'(3'b001 << rr_exp[k]));
      tick();
      check_out("rr", 1'b1, 32'h10 * (32'(rr_exp[k]) + 32'd1), rr_exp[k]);
    end
    bus.RECEIVE_VALID = '0;
    tick();

    // Backpressure: 0x55 held while ch2 waits
    bus.RECEIVE_VALID = 3'b001;
    set_ch(0, 32'h55);
    #1;
    check("bp_first_ready", 64'(bus.RECEIVE_READY), 64'(3'b001));
    tick();
    check_out("bp_capture", 1'b1, 32'h55, 2'd0);
    bus.RECEIVE_VALID = 3'b100;
    set_ch(2, 32'h77);
    bus.SEND_READY = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_stall_ready", 64'(bus.RECEIVE_READY), 64'(3'b000));
      tick();
      check_out("bp_hold", 1'b1, 32'h55, 2'd0);
    end
    bus.SEND_READY = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.RECEIVE_READY), 64'(3'b100));
    tick();
    check_out("bp_next", 1'b1, 32'h77, 2'd2);
    bus.RECEIVE_VALID = '0;
    tick();
    check("bp_drain", 64'(bus.SEND_VALID), 64'(0));

    // Skip idle channel: only ch0 and ch2 valid
    set_ch(0, 32'hC0);
    set_ch(2, 32'hC2);
    bus.RECEIVE_VALID = 3'b101;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("skip_ready", 64'(bus.RECEIVE_READY), 64'(3'b001 << skip_exp[k]));
      tick();
      check_out("skip", 1'b1, (skip_exp[k] == 2'd0) ? 32'hC0 : 32'hC2, skip_exp[k]);
    end
    bus.RECEIVE_VALID = '0;
    tick();

    // Reset mid-operation discards the buffered word
    bus.RECEIVE_VALID = 3'b001;
    set_ch(0, 32'h99);
    tick();
    check_out("mid_capture", 1'b1, 32'h99, 2'd0);
    bus.RECEIVE_VALID = '0;
    bus.SEND_READY = 1'b0;
    tick();
    check_out("mid_hold", 1'b1, 32'h99, 2'd0);
    RST = 1'b1;
    bus.RECEIVE_VALID = 3'b110;
    set_ch(1, 32'hD1);
    set_ch(2, 32'hD2);
    tick();
    check_out("mid_reset", 1'b0, '0, '0);
    RST = 1'b0;
    bus.RECEIVE_VALID = 3'b111;
    set_ch(0, 32'hD0);
    bus.SEND_READY = 1'b1;
    #1;
    check("mid_after_ready", 64'(bus.RECEIVE_READY), 64'(3'b001));
    tick();
    check_out("mid_after", 1'b1, 32'hD0, 2'd0);
    bus.RECEIVE_VALID = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
